eth_tx_frame_streamer: RTL and testbench

ETH_TX_FRAME_STREAMER -- requirements
Module: eth_tx_frame_streamer

---
 rtl/eth_tx_frame_streamer_if.sv | 17 +
 rtl/eth_tx_frame_streamer.sv | 135 +++++++++++++
 tb/tb_eth_tx_frame_streamer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_frame_streamer_if.sv
// AXI-stream transmit link from the frame streamer towards the Ethernet MAC.
interface eth_tx_frame_streamer_if;
    logic [7:0] tx_axis_mac_tdata;
    logic       tx_axis_mac_tvalid;
    logic       tx_axis_mac_tlast;
    logic       tx_axis_mac_tuser;
    logic       tx_axis_mac_tready;

    modport master (
        output tx_axis_mac_tdata, tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tuser,
        input  tx_axis_mac_tready
    );
    modport slave (
        input  tx_axis_mac_tdata, tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tuser,
        output tx_axis_mac_tready
    );
endinterface

// File: rtl/eth_tx_frame_streamer.sv
// Buffers one frame byte-by-byte, then streams it to the MAC over AXI-stream with abort support.
// Optional macro ETH_TX_PAD_EN: zero-pad short frames up to MIN_LEN beats.
module eth_tx_frame_streamer #(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 60
) (
    input  logic              tx_mac_aclk,
    input  logic              tx_reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              send,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              wr_ovf,
    output logic [ADDR_W:0]   len,
    eth_tx_frame_streamer_if.master axis
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] MIN_LEN_W = (ADDR_W+1)'(MIN_LEN);
`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d, rd_ptr_q, rd_ptr_d, total;
    logic [7:0]      tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic            abort_pend_q, abort_pend_d, wr_ovf_q, wr_ovf_d;
    logic            wr_ok, accept, load, mark;
    logic [7:0]      mem [DEPTH];

    assign total  = (PAD_EN && (len_q < MIN_LEN_W)) ? MIN_LEN_W : len_q;
    assign wr_ok  = wr_en && (state_q == IDLE) && (len_q != FULL);
    assign accept = tvalid_q && axis.tx_axis_mac_tready;
    // A pending or same-cycle abort turns the next loaded beat into the bad-frame terminator.
    assign mark   = abort || abort_pend_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_ptr_d     = rd_ptr_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        abort_pend_d = abort_pend_q;
        wr_ovf_d     = wr_ovf_q | (wr_en & ~wr_ok);
        load         = 1'b0;
        if (wr_ok) len_d = len_q + 1'b1;
        case (state_q)
            IDLE: begin
                // Same-cycle write counts towards the frame, so test the post-write length.
                if (send && ((len_q != '0) || wr_ok)) begin
                    state_d      = FETCH;
                    rd_ptr_d     = '0;
                    abort_pend_d = 1'b0;
                end
            end
            FETCH: begin
                load    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (tlast_q) begin
                        state_d  = FLUSH;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tuser_d  = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end else if (abort && !tlast_q) begin
                    abort_pend_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                len_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            tdata_d      = (rd_ptr_q < len_q) ? mem[rd_ptr_q[ADDR_W-1:0]] : 8'h00;
            tvalid_d     = 1'b1;
            tlast_d      = (rd_ptr_q == total - 1'b1) || mark;
            tuser_d      = mark;
            rd_ptr_d     = rd_ptr_q + 1'b1;
            abort_pend_d = 1'b0;
        end
    end

    always_ff @(posedge tx_mac_aclk) begin
        if (wr_ok) mem[len_q[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge tx_mac_aclk) begin
        if (tx_reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            rd_ptr_q     <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            wr_ovf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_ptr_q     <= rd_ptr_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            abort_pend_q <= abort_pend_d;
            wr_ovf_q     <= wr_ovf_d;
        end
    end

    assign busy                    = (state_q != IDLE);
    assign done                    = (state_q == FLUSH);
    assign wr_ovf                  = wr_ovf_q;
    assign len                     = len_q;
    assign axis.tx_axis_mac_tdata  = tdata_q;
    assign axis.tx_axis_mac_tvalid = tvalid_q;
    assign axis.tx_axis_mac_tlast  = tlast_q;
    assign axis.tx_axis_mac_tuser  = tuser_q;
endmodule

// File: tb/tb_eth_tx_frame_streamer.sv
// Self-checking bench: table of frame scenarios plus hand-written overflow/reset sequences.
module tb_eth_tx_frame_streamer;
    localparam int ADDR_W  = 11;
    localparam int MIN_LEN = 60;
`ifdef ETH_TX_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    logic              clk = 1'b0;
    logic              tx_reset, wr_en, send, abort;
    logic [7:0]        wr_data;
    logic              busy, done, wr_ovf;
    logic [ADDR_W:0]   len;
    int                errors = 0;
    int                checks = 0;

    eth_tx_frame_streamer_if axis_if ();

    eth_tx_frame_streamer #(.ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN)) dut (
        .tx_mac_aclk(clk), .tx_reset(tx_reset), .wr_en(wr_en), .wr_data(wr_data),
        .send(send), .abort(abort), .busy(busy), .done(done), .wr_ovf(wr_ovf),
        .len(len), .axis(axis_if.master)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
    typedef struct { int n; int base; int mode; int abort_after; int reset_at; int beats; } vec_t;

    beat_t exp_q[$];

    function automatic int padded(input int n);
        return (PAD != 0 && n < MIN_LEN) ? MIN_LEN : n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = 8'((base + i) & 8'hFF);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return 1'($urandom_range(0, 1));
    endfunction

    // Pushes the frame, sends it, consumes beats against the scoreboard; ends after IDLE or reset.
    task automatic run_frame(input vec_t v, input bit busy_wr);
        beat_t b;
        int    got, first, last_cyc, exp_n;
        bit    stop, seen_done;
        logic  pv, pr, pl, pu;
        logic [7:0] pd;
        push_bytes(v.n, v.base);
        check("len_loaded", 32'(len), v.n);
        exp_n = (v.reset_at > 0) ? v.reset_at : v.beats;
        for (int k = 0; k < exp_n; k++) begin
            b.data = (k < v.n) ? 8'((v.base + k) & 8'hFF) : 8'h00;
            b.last = (v.reset_at <= 0) && (k == exp_n - 1);
            b.user = (v.abort_after > 0) && (k == exp_n - 1);
            exp_q.push_back(b);
        end
        send = 1'b1;
        axis_if.tx_axis_mac_tready = rdy(v.mode, 0);
        got = 0; first = -1; last_cyc = -1; stop = 0; seen_done = 0;
        pv = 0; pr = 0; pl = 0; pu = 0; pd = 0;
        for (int cyc = 0; cyc < 6000 && !stop; cyc++) begin
            @(negedge clk);
            if (axis_if.tx_axis_mac_tvalid && first < 0) first = cyc;
            if (pv && !pr)
                check("stall_hold",
                      32'({axis_if.tx_axis_mac_tvalid, axis_if.tx_axis_mac_tlast,
                           axis_if.tx_axis_mac_tuser, axis_if.tx_axis_mac_tdata}),
                      32'({1'b1, pl, pu, pd}));
            if (done) begin
                stop = 1; seen_done = 1;
                check("done_after_last", cyc, last_cyc + 1);
            end else if (axis_if.tx_axis_mac_tvalid && axis_if.tx_axis_mac_tready) begin
                got++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got beat %0d data 0x%0h, none expected", got,
                             axis_if.tx_axis_mac_tdata);
                end else begin
                    b = exp_q.pop_front();
                    check("beat", 32'({axis_if.tx_axis_mac_tlast, axis_if.tx_axis_mac_tuser,
                                       axis_if.tx_axis_mac_tdata}),
                          32'({b.last, b.user, b.data}));
                end
                last_cyc = cyc;
                if (got == v.abort_after) abort = 1'b1;
                if (got == v.reset_at) begin tx_reset = 1'b1; stop = 1; end
            end
            pv = axis_if.tx_axis_mac_tvalid; pr = axis_if.tx_axis_mac_tready;
            pl = axis_if.tx_axis_mac_tlast;  pu = axis_if.tx_axis_mac_tuser;
            pd = axis_if.tx_axis_mac_tdata;
            @(posedge clk); #1;
            send  = 1'b0;
            abort = 1'b0;
            wr_en = busy_wr && (cyc == 0);
            wr_data = 8'hEE;
            axis_if.tx_axis_mac_tready = rdy(v.mode, cyc + 1);
        end
        wr_en = 1'b0;
        check("first_tvalid_cycle", first, 2);
        check("beats_outstanding", exp_q.size(), 0);
        exp_q.delete();
        if (v.reset_at > 0) begin
            check("rst_outputs", 32'({axis_if.tx_axis_mac_tvalid, axis_if.tx_axis_mac_tlast, busy}), 0);
            check("rst_len", 32'(len), 0);
            tx_reset = 1'b0;
        end else begin
            check("saw_done", 32'(seen_done), 1);
            check("post_frame", 32'({busy, done, axis_if.tx_axis_mac_tvalid}), 0);
            check("post_len", 32'(len), 0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t hv;
        vecs[0] = '{n:64,  base:8'h00, mode:0, abort_after:-1, reset_at:-1, beats:64};
        vecs[1] = '{n:64,  base:8'h00, mode:1, abort_after:-1, reset_at:-1, beats:64};
        vecs[2] = '{n:10,  base:8'hA0, mode:0, abort_after:-1, reset_at:-1, beats:padded(10)};
        vecs[3] = '{n:100, base:8'h00, mode:0, abort_after:20, reset_at:-1, beats:21};
        vecs[4] = '{n:5,   base:8'h10, mode:2, abort_after:-1, reset_at:-1, beats:padded(5)};
        vecs[5] = '{n:100, base:8'h40, mode:0, abort_after:-1, reset_at:30, beats:100};

        tx_reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0; abort = 1'b0;
        axis_if.tx_axis_mac_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({busy, done, wr_ovf}), 0);
        check("reset_len", 32'(len), 0);
        check("reset_axis", 32'({axis_if.tx_axis_mac_tvalid, axis_if.tx_axis_mac_tlast,
                                 axis_if.tx_axis_mac_tuser, axis_if.tx_axis_mac_tdata}), 0);
        tx_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0);
            check("no_ovf", 32'(wr_ovf), 0);
        end

        // Fill the buffer exactly, then one extra byte must be dropped.
        push_bytes(2048, 0);
        check("full_len", 32'(len), 2048);
        check("full_no_ovf", 32'(wr_ovf), 0);
        push_bytes(1, 8'h55);
        check("over_len", 32'(len), 2048);
        check("over_ovf", 32'(wr_ovf), 1);

        @(posedge clk); #1; tx_reset = 1'b1;
        @(posedge clk); #1; tx_reset = 1'b0;
        check("rst_clears_ovf", 32'({wr_ovf, busy}), 0);
        check("rst_clears_len", 32'(len), 0);

        // Send with nothing buffered must be ignored.
        send = 1'b1;
        @(posedge clk); #1; send = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("empty_send_idle", 32'({busy, axis_if.tx_axis_mac_tvalid}), 0);
        end

        // Write during a frame in flight is dropped and flagged.
        @(posedge clk); #1;
        hv = '{n:3, base:8'hC0, mode:0, abort_after:-1, reset_at:-1, beats:padded(3)};
        run_frame(hv, 1'b1);
        check("busy_wr_ovf", 32'(wr_ovf), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
